// File: rtl/color_pkg.sv
// Shared types for the colour-tracking controller.
//   color_e : colour code from the colour detector (NONE/RED/GREEN/BLUE)
//   state_e : controller FSM states
package color_pkg;

  localparam int unsigned COLOR_W = 2;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [COLOR_W-1:0] {
    NONE  = 2'd0,
    RED   = 2'd1,
    GREEN = 2'd2,
    BLUE  = 2'd3
  } color_e;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 3'd0,
    WAIT_COLOR = 3'd1,
    WAIT_VSYNC = 3'd2,
    STREAM     = 3'd3,
    WAIT_CENT  = 3'd4,
    DONE       = 3'd5
  } state_e;

  // States guarded by the watchdog.
  function automatic logic is_wait_state(input state_e s);
    return (s == WAIT_COLOR) || (s == WAIT_VSYNC) || (s == WAIT_CENT);
  endfunction

endpackage

// File: rtl/wdog_timer.sv
// Watchdog for the controller's waiting states.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart the count (state entry)
//   enable   : count while high
//   expired  : registered, high once TIMEOUT cycles have elapsed since clear
module wdog_timer #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 1) ? TIMEOUT - 1 : 0);
  localparam logic EXP_ON_CLEAR = (TIMEOUT <= 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = CNT_W'(cnt + 1'b1);

  // The clear cycle counts as the first waited cycle, so the consumer
  // reacts to expired exactly TIMEOUT cycles after entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      expired <= EXP_ON_CLEAR;
    end else if (enable && !expired) begin
      cnt     <= cnt_inc;
      expired <= (cnt_inc == CNT_LAST);
    end
  end

endmodule

// File: rtl/color_track_ctrl.sv
// Sequencer for one colour-tracking measurement: wait for a colour result,
// gate one camera frame through the colour filter, then wait for the
// centroid unit.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : request one measurement (accepted only in IDLE)
//   veml_ready, parcel_color : colour-detector strobe and code
//   vsync, pix_valid    : camera frame boundary and pixel strobe
//   cent_done           : centroid result valid
//   filt_en, filt_color : filter enable and latched colour code
//   frame_start, frame_end : one-cycle pulses to centroid unit
//   busy, done, err     : status (err sticky until the next accepted start)
module color_track_ctrl
  import color_pkg::*;
#(
  parameter int unsigned IMG_W   = 640,
  parameter int unsigned IMG_H   = 480,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               veml_ready,
  input  logic [COLOR_W-1:0] parcel_color,
  input  logic               vsync,
  input  logic               pix_valid,
  input  logic               cent_done,
  output logic               filt_en,
  output logic [COLOR_W-1:0] filt_color,
  output logic               frame_start,
  output logic               frame_end,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);

  state_e             state, state_n;
  logic [PIX_W-1:0]   pix_cnt, pix_cnt_n;
  logic               filt_en_n;
  logic [COLOR_W-1:0] filt_color_n;
  logic               frame_start_n;
  logic               frame_end_n;
  logic               err_n;
  logic               wd_clear;
  logic               wd_enable;
  logic               wd_expired;

  // Watchdog restarts on every state change and runs only in waiting states.
  assign wd_clear  = (state_n != state);
  assign wd_enable = is_wait_state(state);

  wdog_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // State and output registers; done/busy follow the next state directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pix_cnt     <= '0;
      filt_en     <= 1'b0;
      filt_color  <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      pix_cnt     <= pix_cnt_n;
      filt_en     <= filt_en_n;
      filt_color  <= filt_color_n;
      frame_start <= frame_start_n;
      frame_end   <= frame_end_n;
      busy        <= (state_n != IDLE);
      done        <= (state_n == DONE);
      err         <= err_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n       = state;
    pix_cnt_n     = pix_cnt;
    filt_en_n     = filt_en;
    filt_color_n  = filt_color;
    frame_start_n = 1'b0;
    frame_end_n   = 1'b0;
    err_n         = err;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = WAIT_COLOR;
          err_n   = 1'b0;
        end
      end

      WAIT_COLOR: begin
        if (veml_ready) begin
          if (color_e'(parcel_color) != NONE) begin
            filt_color_n = parcel_color;
            state_n      = WAIT_VSYNC;
          end else begin
            err_n   = 1'b1;
            state_n = DONE;
          end
        end else if (wd_expired) begin
          err_n     = 1'b1;
          filt_en_n = 1'b0;
          state_n   = DONE;
        end
      end

      WAIT_VSYNC: begin
        if (vsync) begin
          filt_en_n     = 1'b1;
          frame_start_n = 1'b1;
          pix_cnt_n     = '0;
          state_n       = STREAM;
        end else if (wd_expired) begin
          err_n     = 1'b1;
          filt_en_n = 1'b0;
          state_n   = DONE;
        end
      end

      STREAM: begin
        // Final pixel takes priority over a coincident vsync.
        if (pix_valid && (pix_cnt == PIX_LAST)) begin
          filt_en_n   = 1'b0;
          frame_end_n = 1'b1;
          state_n     = WAIT_CENT;
        end else if (vsync) begin
          err_n       = 1'b1;
          filt_en_n   = 1'b0;
          frame_end_n = 1'b1;
          state_n     = DONE;
        end else if (pix_valid) begin
          pix_cnt_n = PIX_W'(pix_cnt + 1'b1);
        end
      end

      WAIT_CENT: begin
        if (cent_done) begin
          state_n = DONE;
        end else if (wd_expired) begin
          err_n     = 1'b1;
          filt_en_n = 1'b0;
          state_n   = DONE;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n   = IDLE;
        filt_en_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_color_track_ctrl.sv
module tb_color_track_ctrl;

  localparam int unsigned IMG_W   = 4;
  localparam int unsigned IMG_H   = 2;
  localparam int unsigned TIMEOUT = 16;
  localparam int NPIX = IMG_W * IMG_H;

  localparam int K_CENT  = 0;
  localparam int K_SHORT = 1;
  localparam int K_TMO   = 2;
  localparam int K_COINC = 3;

  logic       clk;
  logic       rst;
  logic       start;
  logic       veml_ready;
  logic [1:0] parcel_color;
  logic       vsync;
  logic       pix_valid;
  logic       cent_done;
  logic       filt_en;
  logic [1:0] filt_color;
  logic       frame_start;
  logic       frame_end;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  // monitor totals (written only by the monitor)
  int cyc       = 0;
  int fs_total  = 0;
  int fe_total  = 0;
  int fen_total = 0;
  int done_total = 0;

  // model state: colour the filter should currently present
  logic [1:0] model_color;

  color_track_ctrl #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .veml_ready   (veml_ready),
    .parcel_color (parcel_color),
    .vsync        (vsync),
    .pix_valid    (pix_valid),
    .cent_done    (cent_done),
    .filt_en      (filt_en),
    .filt_color   (filt_color),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_start === 1'b1) fs_total  <= fs_total + 1;
    if (frame_end   === 1'b1) fe_total  <= fe_total + 1;
    if (filt_en     === 1'b1) fen_total <= fen_total + 1;
    if (done        === 1'b1) done_total <= done_total + 1;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done; returns the cycle number it was seen in.
  task automatic wait_done(output bit found, output int at_cyc);
    found  = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found  = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    start = 0; veml_ready = 0; parcel_color = 0; vsync = 0;
    pix_valid = 0; cent_done = 0;
    rst = 1;
    tick(); tick();
    @(negedge clk);
    n_checks++;
    if ({filt_en, filt_color, frame_start, frame_end, busy, done, err} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 00000000",
               {filt_en, filt_color, frame_start, frame_end, busy, done, err});
    end
    tick();
    rst = 0;
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy/done got %b required 00", {busy, done});
    end
    model_color = 2'd0;
  endtask

  // One measurement; expected results derived from the controller's rules.
  task automatic run_scenario(input logic [1:0] c, input int kind,
                              input int npix, input bit noisy);
    int  fs0, fe0, fen0, d0, g, last_edge, at_cyc, npx;
    bit  found;
    bit  exp_err, exp_fs, exp_fe, exp_fen;
    int  exp_lat;
    logic [1:0] exp_col;

    if (c == 2'd0) begin
      exp_err = 1; exp_fs = 0; exp_fe = 0; exp_fen = 0; exp_lat = 0;
      exp_col = model_color;
    end else begin
      exp_fs = 1; exp_fe = 1; exp_fen = 1; exp_col = c;
      exp_err = (kind == K_SHORT) || (kind == K_TMO);
      exp_lat = (kind == K_TMO) ? TIMEOUT : 0;
    end

    fs0 = fs_total; fe0 = fe_total; fen0 = fen_total; d0 = done_total;

    start = 1; tick(); start = 0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: got %b required 1", busy);
    end
    g = $urandom_range(0, 3);
    repeat (g) tick();
    veml_ready = 1; parcel_color = c; tick();
    veml_ready = 0; parcel_color = 2'($urandom);
    last_edge = cyc;

    if (c != 2'd0) begin
      g = $urandom_range(0, 3);
      repeat (g) begin
        if (noisy) begin
          pix_valid = 1'($urandom);
          cent_done = 1'($urandom);
        end
        tick();
      end
      pix_valid = 0; cent_done = 0;
      vsync = 1; tick(); vsync = 0;
      npx = (kind == K_SHORT) ? npix : NPIX;
      for (int i = 0; i < npx; i++) begin
        g = $urandom_range(0, 2);
        repeat (g) begin
          if (noisy) start = 1'($urandom);
          tick();
        end
        start = 0;
        pix_valid = 1;
        if (kind == K_COINC && i == npx - 1) vsync = 1;
        tick();
        pix_valid = 0; vsync = 0;
      end
      last_edge = cyc;
      if (kind == K_SHORT) begin
        vsync = 1; tick(); vsync = 0;
        last_edge = cyc;
      end else if (kind == K_CENT || kind == K_COINC) begin
        g = $urandom_range(0, 3);
        repeat (g) tick();
        cent_done = 1; tick(); cent_done = 0;
        last_edge = cyc;
      end
    end

    wait_done(found, at_cyc);
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL done_seen c=%0d kind=%0d: no done within bound", c, kind);
    end else begin
      n_checks++;
      if (err !== exp_err) begin
        n_fail++;
        $display("FAIL err_at_done c=%0d kind=%0d: got %b required %b", c, kind, err, exp_err);
      end
      n_checks++;
      if (filt_color !== exp_col) begin
        n_fail++;
        $display("FAIL filt_color c=%0d kind=%0d: got %0d required %0d", c, kind, filt_color, exp_col);
      end
      n_checks++;
      if (at_cyc - last_edge !== exp_lat) begin
        n_fail++;
        $display("FAIL done_latency c=%0d kind=%0d: got %0d required %0d",
                 c, kind, at_cyc - last_edge, exp_lat);
      end
      n_checks++;
      if (filt_en !== 1'b0) begin
        n_fail++;
        $display("FAIL filt_en_at_done c=%0d kind=%0d: got %b required 0", c, kind, filt_en);
      end
      @(negedge clk);
      n_checks++;
      if ({done, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL done_one_cycle c=%0d kind=%0d: done/busy got %b required 00",
                 c, kind, {done, busy});
      end
    end
    tick();
    n_checks++;
    if (fs_total - fs0 !== int'(exp_fs)) begin
      n_fail++;
      $display("FAIL frame_start_count c=%0d kind=%0d: got %0d required %0d",
               c, kind, fs_total - fs0, exp_fs);
    end
    n_checks++;
    if (fe_total - fe0 !== int'(exp_fe)) begin
      n_fail++;
      $display("FAIL frame_end_count c=%0d kind=%0d: got %0d required %0d",
               c, kind, fe_total - fe0, exp_fe);
    end
    n_checks++;
    if ((fen_total != fen0) !== exp_fen) begin
      n_fail++;
      $display("FAIL filt_en_seen c=%0d kind=%0d: got %b required %b",
               c, kind, (fen_total != fen0), exp_fen);
    end
    n_checks++;
    if (done_total - d0 !== 1) begin
      n_fail++;
      $display("FAIL done_count c=%0d kind=%0d: got %0d required 1", c, kind, done_total - d0);
    end
    model_color = exp_col;
  endtask

  task automatic test_full_frame();
    run_scenario(2'd2, K_CENT, 0, 1'b0);
  endtask

  task automatic test_color_none();
    run_scenario(2'd0, K_CENT, 0, 1'b0);
  endtask

  task automatic test_short_frame();
    run_scenario(2'd3, K_SHORT, 5, 1'b0);
  endtask

  task automatic test_cent_timeout();
    run_scenario(2'd1, K_TMO, 0, 1'b0);
  endtask

  task automatic test_coincident_vsync();
    run_scenario(2'd1, K_COINC, 0, 1'b1);
  endtask

  task automatic test_wait_timeouts();
    bit found;
    int at_cyc, last_edge, fs0;
    fs0 = fs_total;
    start = 1; tick(); start = 0;
    last_edge = cyc;
    wait_done(found, at_cyc);
    n_checks++;
    if (!found || (at_cyc - last_edge) !== TIMEOUT || err !== 1'b1) begin
      n_fail++;
      $display("FAIL color_timeout: found=%b latency=%0d err=%b required 1/%0d/1",
               found, at_cyc - last_edge, err, TIMEOUT);
    end
    tick(); tick();
    start = 1; tick(); start = 0;
    veml_ready = 1; parcel_color = 2'd3; tick(); veml_ready = 0;
    last_edge = cyc;
    wait_done(found, at_cyc);
    n_checks++;
    if (!found || (at_cyc - last_edge) !== TIMEOUT || err !== 1'b1 || filt_color !== 2'd3) begin
      n_fail++;
      $display("FAIL vsync_timeout: found=%b latency=%0d err=%b color=%0d required 1/%0d/1/3",
               found, at_cyc - last_edge, err, filt_color, TIMEOUT);
    end
    tick(); tick();
    n_checks++;
    if (fs_total !== fs0) begin
      n_fail++;
      $display("FAIL timeout_no_frame_start: got %0d pulses required 0", fs_total - fs0);
    end
    model_color = 2'd3;
  endtask

  task automatic test_mid_reset();
    int fe0, d0;
    fe0 = fe_total; d0 = done_total;
    start = 1; tick(); start = 0;
    veml_ready = 1; parcel_color = 2'd1; tick(); veml_ready = 0;
    vsync = 1; tick(); vsync = 0;
    repeat (3) begin
      pix_valid = 1; tick(); pix_valid = 0;
    end
    rst = 1; tick();
    @(negedge clk);
    n_checks++;
    if ({filt_en, filt_color, frame_start, frame_end, busy, done, err} !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %b required 00000000",
               {filt_en, filt_color, frame_start, frame_end, busy, done, err});
    end
    tick(); rst = 0;
    repeat (20) tick();
    n_checks++;
    if (fe_total - fe0 !== 0 || done_total - d0 !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_abort: frame_end=%0d done=%0d required 0/0",
               fe_total - fe0, done_total - d0);
    end
    model_color = 2'd0;
    run_scenario(2'd2, K_CENT, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      run_scenario(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, NPIX - 1)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_color_none();
    test_short_frame();
    test_cent_timeout();
    test_coincident_vsync();
    test_wait_timeouts();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
